// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 stream demux; packet lane locked on first beat. Optional DEMUX_STATS_EN adds per-lane drain counters.
// Latency: 1 clock from input accept to lane out_valid; one beat per clock per lane sustained.
// Backpressure: in_ready drops only when the target lane buffer is full and its consumer is stalled.
module stream_demux_1to4 #(
    parameter int DATA_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    input  logic [1:0]          in_sel,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [4*DATA_W-1:0] out_data,
    output logic [3:0]          out_last
`ifdef DEMUX_STATS_EN
    ,
    output logic [63:0]         beat_cnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] route_q;
    logic [1:0] tgt;
    logic       accept;

    // Mid-packet the locked lane wins; in_sel only matters on a first beat.
    assign tgt      = (state == ROUTE) ? route_q : in_sel;
    assign in_ready = ~out_valid[tgt] | out_ready[tgt];
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            route_q <= 2'd0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (!in_last) begin
                        route_q <= in_sel;
                        state   <= ROUTE;
                    end
                end
                ROUTE: begin
                    if (in_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A load takes priority over a drain so a lane can pass one beat per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 4'b0000;
            out_data  <= '0;
            out_last  <= 4'b0000;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && (tgt == 2'(k))) begin
                    out_valid[k]                <= 1'b1;
                    out_data[k*DATA_W +: DATA_W] <= in_data;
                    out_last[k]                 <= in_last;
                end else if (out_valid[k] && out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

`ifdef DEMUX_STATS_EN
    logic [15:0] cnt_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= 16'd0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k] && (cnt_q[k] != 16'hFFFF)) begin
                    cnt_q[k] <= cnt_q[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        beat_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            beat_cnt[k*16 +: 16] = cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Scoreboard bench for stream_demux_1to4: per-lane expected queues filled on accept, drained by a negedge monitor.
module tb_stream_demux_1to4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_data = 4'h0;
    logic        in_last = 1'b0;
    logic [1:0]  in_sel = 2'd0;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'b1111;
    logic [15:0] out_data;
    logic [3:0]  out_last;
`ifdef DEMUX_STATS_EN
    logic [63:0] beat_cnt;
`endif

    int checks = 0;
    int failures = 0;
    int last_wait = 0;

    logic [4:0] sbq [0:3][$];
    logic       m_locked = 1'b0;
    logic [1:0] m_route = 2'd0;

    stream_demux_1to4 #(.DATA_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef DEMUX_STATS_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Bench-side model of the handshake: which lane takes the beat and how the lock moves.
    task automatic model_accept();
        logic [1:0] lane;
        lane = m_locked ? m_route : in_sel;
        sbq[lane].push_back({in_last, in_data});
        if (!m_locked && !in_last) begin
            m_locked = 1'b1;
            m_route  = in_sel;
        end else if (m_locked && in_last) begin
            m_locked = 1'b0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] sel, input logic [3:0] dat, input logic lst);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = dat;
        in_last  = lst;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            #1;
            if (in_ready) begin
                model_accept();
                last_wait = w;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) sbq[k].delete();
        m_locked = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: outputs checked against queue occupancy, drains popped and compared.
    always @(negedge clk) begin
        logic [3:0] occ;
        logic [1:0] t;
        logic [4:0] item;
        if (!rst_n) begin
            chk("rst_out_valid", out_valid, 4'b0000);
            chk("rst_out_data", out_data, 16'h0000);
            chk("rst_out_last", out_last, 4'b0000);
        end else begin
            for (int k = 0; k < 4; k++) occ[k] = (sbq[k].size() != 0);
            t = m_locked ? m_route : in_sel;
            chk("in_ready_eq", in_ready, !occ[t] || out_ready[t]);
            chk("out_valid", out_valid, occ);
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k] && sbq[k].size() != 0) begin
                    item = sbq[k].pop_front();
                    chk($sformatf("lane%0d_data", k), out_data[k*4 +: 4], item[3:0]);
                    chk($sformatf("lane%0d_last", k), out_last[k], item[4]);
                end
            end
        end
    end

    initial begin
        // Reset held with a valid beat presented; monitor checks zero outputs.
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 4'h9;
        in_last  = 1'b1;
        do_reset(4);
        send(2'd2, 4'h9, 1'b1);
        chk("first_after_rst_lane2", out_valid, 4'b0100);

        // Single-beat packet on lane 3.
        send(2'd3, 4'hE, 1'b1);
        chk("single_valid", out_valid, 4'b1000);
        chk("single_data", out_data[15:12], 4'hE);
        chk("single_last", out_last[3], 1'b1);

        // Lock: in_sel changes mid-packet are ignored.
        send(2'd1, 4'h3, 1'b0);
        send(2'd2, 4'hD, 1'b0);
        chk("lock_mid_lane1", out_valid, 4'b0010);
        send(2'd2, 4'h7, 1'b1);
        chk("lock_end_lane1", out_valid, 4'b0010);
        chk("lock_end_data", out_data[7:4], 4'h7);
        send(2'd0, 4'h5, 1'b1);
        chk("idle_after_lock", out_valid, 4'b0001);

        // Gap inside a packet keeps the lock.
        send(2'd3, 4'hA, 1'b0);
        in_sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        send(2'd0, 4'hB, 1'b1);
        chk("gap_lock_lane3", out_data[15:12], 4'hB);

        // Back-pressure on lane 2 while lane 0 keeps flowing.
        out_ready = 4'b1011;
        send(2'd2, 4'h1, 1'b1);
        in_valid = 1'b1;
        in_sel   = 2'd2;
        in_data  = 4'h2;
        in_last  = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_in_ready_low", in_ready, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        send(2'd0, 4'h6, 1'b1);
        chk("bp_lane0_pass", out_data[3:0], 4'h6);
        chk("bp_lane2_hold", out_data[11:8], 4'h1);
        out_ready = 4'b1111;
        send(2'd2, 4'h2, 1'b1);
        chk("bp_same_cycle", last_wait, 0);
        chk("bp_replaced", out_data[11:8], 4'h2);

        // Reset mid-packet drops buffered beats and the lock.
        out_ready = 4'b0000;
        send(2'd1, 4'hC, 1'b0);
        do_reset(2);
        out_ready = 4'b1111;
        send(2'd3, 4'h4, 1'b1);
        chk("post_rst_route", out_valid, 4'b1000);

        // Random stress against the per-lane model.
        for (int c = 0; c < 5000; c++) begin
            out_ready = 4'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom);
            in_data   = 4'($urandom);
            in_last   = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            #1;
            if (in_valid && in_ready) model_accept();
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) chk($sformatf("drained_lane%0d", k), sbq[k].size(), 0);

`ifdef DEMUX_STATS_EN
        do_reset(2);
        out_ready = 4'b1111;
        for (int i = 0; i < 70000; i++) send(2'd0, i[3:0], 1'b1);
        for (int i = 0; i < 5; i++) send(2'd2, i[3:0], 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("stat_lane0_sat", beat_cnt[15:0], 16'hFFFF);
        chk("stat_lane1", beat_cnt[31:16], 16'd0);
        chk("stat_lane2", beat_cnt[47:32], 16'd5);
        chk("stat_lane3", beat_cnt[63:48], 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_demux_1to4.md
Name: stream_demux_1to4

Overview:
Registered 1-to-4 stream demultiplexer, the distribution end of the 4:1 multiplexer datapath. It takes one valid/ready input stream and steers each packet to one of four output lanes selected by a 2-bit select. The select is locked for the whole packet. Each lane has a one-entry output buffer, so all outputs are registered while full throughput is kept.

Parameters:
DATA_W, 4, data width of the input beat and of each output lane.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  input beat valid.
in_ready  output  1  input beat accepted this cycle when high together with in_valid.
in_data  input  DATA_W  input beat payload.
in_last  input  1  marks the final beat of a packet.
in_sel  input  2  destination lane; sampled only on the first beat of a packet.
out_valid  output  4  per-lane valid; bit k belongs to lane k.
out_ready  input  4  per-lane ready from the downstream consumers.
out_data  output  4*DATA_W  lane k payload at bits [k*DATA_W +: DATA_W].
out_last  output  4  per-lane last flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, route_q = 0.
  - All lane buffers empty: out_valid = 4'b0000, out_data = 0, out_last = 4'b0000.
  - Reset mid-packet discards all buffered beats and the lock. After release, the next accepted beat is treated as a first beat.
- Target lane t:
  - in IDLE, t = in_sel;
  - in ROUTE, t = route_q, and in_sel is ignored.
- in_ready = ~out_valid[t] | out_ready[t]. This path is combinational from in_sel/route_q and out_ready. There are no other combinational paths from input to output.
- Accept = in_valid & in_ready. On accept, lane t buffer loads in_data and in_last, and out_valid[t] = 1 on the next cycle. Latency is 1 clock.
- Lane k drains when out_valid[k] & out_ready[k]. The buffer clears next cycle unless it is loaded in the same cycle.
- Simultaneous drain and load on the same lane: the new beat replaces the old one and out_valid stays 1. This gives back-to-back one beat per clock with no bubble.
- Lanes drain independently. A stalled lane never blocks draining of other lanes; it blocks only input beats targeting it.
- Out_data and out_last of a lane hold stable while out_valid is high and out_ready is low.
- FSM:
  - IDLE: accept with in_last = 0 -> route_q <= in_sel, go to ROUTE.
  - IDLE: accept with in_last = 1 -> single-beat packet, stay in IDLE.
  - ROUTE: accept with in_last = 1 -> go to IDLE.
  - ROUTE: any other case -> stay in ROUTE.
  - No accept -> state unchanged.
- in_valid low between beats of a packet is legal. The lock persists and in_sel is don't-care.
- Beats are delivered in order within a lane. No beat is dropped or duplicated.

Optional Feature:
Macro DEMUX_STATS_EN.
- Defined: adds output port beat_cnt, output, 64 bits.
  - Lane k holds a 16-bit count of beats drained from lane k at bits [k*16 +: 16].
  - Each count saturates at 16'hFFFF and is cleared by reset.
  - Counts update on the clock edge of the drain.
- Not defined: port and counters are absent. Datapath behaviour is identical.

Test Plan:
- Reset check: hold rst_n = 0 while in_valid = 1 -> out_valid = 0000, out_data = 0 and out_last = 0000 throughout. First beat after release routes per in_sel.
- Single-beat packet: in_sel = 3, in_data = 4'hE, in_last = 1, out_ready = 1111 -> next cycle out_valid = 1000, lane 3 data = E, out_last[3] = 1, FSM stays in IDLE.
- Packet lock: 3-beat packet {3, D, 7} with in_sel = 1 on beat 0 and in_sel = 2 on beats 1-2 -> all three beats appear on lane 1 in order, with out_last[1] only on beat 7, then IDLE.
- Back-pressure: out_ready[2] = 0, send 2 beats to lane 2 -> first beat buffered and in_ready low on the second. Meanwhile a packet to lane 0 (in_sel = 0 in IDLE) passes. Raising out_ready[2] drains lane 2 and accepts the second beat in the same cycle.
- Random stress: 5000 cycles of random in_sel, in_data, in_last, in_valid and out_ready, checked against a per-lane reference FIFO model -> no loss, reordering or cross-lane leakage, and the in_ready equation holds every cycle.
- Stats (DEMUX_STATS_EN): drain 70000 beats on lane 0 and 5 beats on lane 2 -> beat_cnt[15:0] = FFFF (saturated), lane 2 count = 5, others 0.
